// File: rtl/ram_arb_pkg.sv
// Shared state encoding, port-select constants and default widths for the
// RAM access arbiter.
package ram_arb_pkg;

   localparam int DEF_ADDR_W = 6;
   localparam int DEF_DATA_W = 32;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_MFC = 2'd2,
      DONE     = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mfc_watchdog.sv
// MFC timeout counter: cleared on entry to WAIT_MFC, counts cycles with MFC low,
// and flags expiry on the cycle the count would reach TIMEOUT_CYC.
module mfc_watchdog #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clear,
   input  logic i_count,
   output logic o_expired
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_count) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Expiry is flagged one count early so the FSM lands in DONE exactly when
   // the counter reaches TIMEOUT_CYC.
   assign o_expired = i_count && (r_count == LAST_CNT);

endmodule

// File: rtl/ram_access_arbiter.sv
// Round-robin two-port arbiter/sequencer for a single-ported RAM with MFC handshake.
// Optional MFC timeout (Err outputs, mfc_watchdog) enabled by defining MFC_TIMEOUT_EN.
module ram_access_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DATA_W      = DEF_DATA_W,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              Clock,
   input  logic              Reset_L,
   input  logic              A_Req,
   input  logic              A_Write,
   input  logic [ADDR_W-1:0] A_Addr,
   input  logic [DATA_W-1:0] A_WData,
   output logic              A_Done,
   output logic [DATA_W-1:0] A_RData,
   output logic              A_Err,
   input  logic              B_Req,
   input  logic              B_Write,
   input  logic [ADDR_W-1:0] B_Addr,
   input  logic [DATA_W-1:0] B_WData,
   output logic              B_Done,
   output logic [DATA_W-1:0] B_RData,
   output logic              B_Err,
   output logic [ADDR_W-1:0] RAM_Address,
   output logic              RAM_Read_H_Write_L,
   output logic              RAM_Out_Enable,
   output logic [DATA_W-1:0] RAM_Data_In,
   input  logic [DATA_W-1:0] RAM_Data_Out,
   input  logic              RAM_MFC
);

   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYC must be at least 1");
   end

   arb_state_t        r_state;
   arb_state_t        w_next_state;
   logic              w_any_req;
   logic              w_pick;
   logic              w_timeout;
   logic              r_winner;
   logic              r_last;
   logic              r_write;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;

`ifdef MFC_TIMEOUT_EN
   logic r_err;

   mfc_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .i_clk     (Clock),
      .i_rst_n   (Reset_L),
      .i_clear   (r_state == ISSUE),
      .i_count   ((r_state == WAIT_MFC) && !RAM_MFC),
      .o_expired (w_timeout)
   );

   assign A_Err = A_Done && r_err;
   assign B_Err = B_Done && r_err;
`else
   assign w_timeout = 1'b0;
   assign A_Err     = 1'b0;
   assign B_Err     = 1'b0;
`endif

   assign w_any_req = A_Req | B_Req;

   // A tie goes to the port that was not granted last.
   always_comb begin
      // NOTE: assign a default before any branch so no path leaves the signal
      // unassigned; a missing default infers a latch.
      w_pick = PORT_A;
      if (A_Req && B_Req) begin
         w_pick = (r_last == PORT_A) ? PORT_B : PORT_A;
      end else if (B_Req) begin
         w_pick = PORT_B;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:     if (w_any_req) w_next_state = ISSUE;
         ISSUE:    w_next_state = WAIT_MFC;
         WAIT_MFC: if (RAM_MFC || w_timeout) w_next_state = DONE;
         DONE:     w_next_state = IDLE;
         default:  w_next_state = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      // NOTE: registers use non-blocking assignments so every flop samples the
      // pre-edge values regardless of statement order.
      if (!Reset_L) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge Clock or negedge Reset_L) begin
      if (!Reset_L) begin
         r_winner  <= PORT_A;
         r_last    <= PORT_B;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_a_rdata <= '0;
         r_b_rdata <= '0;
`ifdef MFC_TIMEOUT_EN
         r_err     <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any_req) begin
                  r_winner <= w_pick;
                  r_write  <= (w_pick == PORT_B) ? B_Write : A_Write;
                  r_addr   <= (w_pick == PORT_B) ? B_Addr  : A_Addr;
                  r_wdata  <= (w_pick == PORT_B) ? B_WData : A_WData;
`ifdef MFC_TIMEOUT_EN
                  r_err    <= 1'b0;
`endif
               end
            end
            WAIT_MFC: begin
               if (RAM_MFC) begin
                  if (!r_write) begin
                     if (r_winner == PORT_A) r_a_rdata <= RAM_Data_Out;
                     else                    r_b_rdata <= RAM_Data_Out;
                  end
               end
`ifdef MFC_TIMEOUT_EN
               else if (w_timeout) begin
                  r_err <= 1'b1;
                  if (r_winner == PORT_A) r_a_rdata <= '0;
                  else                    r_b_rdata <= '0;
               end
`endif
            end
            DONE:    r_last <= r_winner;
            default: ;
         endcase
      end
   end

   assign A_Done             = (r_state == DONE) && (r_winner == PORT_A);
   assign B_Done             = (r_state == DONE) && (r_winner == PORT_B);
   assign A_RData            = r_a_rdata;
   assign B_RData            = r_b_rdata;
   assign RAM_Address        = r_addr;
   assign RAM_Data_In        = r_wdata;
   assign RAM_Out_Enable     = (r_state == ISSUE) || (r_state == WAIT_MFC);
   assign RAM_Read_H_Write_L = !((r_state == WAIT_MFC) && r_write);

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed, table-driven bench for ram_access_arbiter; hand-written sequences
// cover reset mid-access, continuous contention and MFC timeout / indefinite wait.
module tb_ram_access_arbiter;
   import ram_arb_pkg::*;

   logic        Clock = 1'b0;
   logic        Reset_L;
   logic        A_Req, A_Write, B_Req, B_Write;
   logic [5:0]  A_Addr, B_Addr;
   logic [31:0] A_WData, B_WData;
   logic        A_Done, B_Done, A_Err, B_Err;
   logic [31:0] A_RData, B_RData;
   logic [5:0]  RAM_Address;
   logic        RAM_Read_H_Write_L, RAM_Out_Enable;
   logic [31:0] RAM_Data_In, RAM_Data_Out;
   logic        RAM_MFC;

   int total = 0;
   int bad   = 0;
   logic [31:0] exp_rd [2];

   typedef struct {
      logic        a_req;
      logic        a_write;
      logic [5:0]  a_addr;
      logic [31:0] a_wdata;
      logic        b_req;
      logic        b_write;
      logic [5:0]  b_addr;
      logic [31:0] b_wdata;
      logic [31:0] ram_rdata;
      int          mfc_wait;
      logic        early;
      logic        drop;
      logic        exp_port;
   } vec_t;

   vec_t vecs [9];

   ram_access_arbiter #(
      .ADDR_W      (6),
      .DATA_W      (32),
      .TIMEOUT_CYC (15)
   ) dut (
      .Clock              (Clock),
      .Reset_L            (Reset_L),
      .A_Req              (A_Req),
      .A_Write            (A_Write),
      .A_Addr             (A_Addr),
      .A_WData            (A_WData),
      .A_Done             (A_Done),
      .A_RData            (A_RData),
      .A_Err              (A_Err),
      .B_Req              (B_Req),
      .B_Write            (B_Write),
      .B_Addr             (B_Addr),
      .B_WData            (B_WData),
      .B_Done             (B_Done),
      .B_RData            (B_RData),
      .B_Err              (B_Err),
      .RAM_Address        (RAM_Address),
      .RAM_Read_H_Write_L (RAM_Read_H_Write_L),
      .RAM_Out_Enable     (RAM_Out_Enable),
      .RAM_Data_In        (RAM_Data_In),
      .RAM_Data_Out       (RAM_Data_Out),
      .RAM_MFC            (RAM_MFC)
   );

   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Applies one access starting in an IDLE cycle (cycle 0) and checks every
   // cycle up to and including the Done cycle (3 + mfc_wait).
   task automatic run_vec(input int idx, input vec_t v);
      int          d;
      logic        wr;
      logic [5:0]  wa;
      logic [31:0] wd;
      d  = 3 + v.mfc_wait;
      wr = v.exp_port ? v.b_write : v.a_write;
      wa = v.exp_port ? v.b_addr  : v.a_addr;
      wd = v.exp_port ? v.b_wdata : v.a_wdata;
      A_Req = v.a_req; A_Write = v.a_write; A_Addr = v.a_addr; A_WData = v.a_wdata;
      B_Req = v.b_req; B_Write = v.b_write; B_Addr = v.b_addr; B_WData = v.b_wdata;
      RAM_Data_Out = v.ram_rdata;
      for (int c = 0; c <= d; c++) begin
         RAM_MFC = (c == 2 + v.mfc_wait) || (v.early && c < 2);
         if (v.drop && c == 1) begin
            if (v.exp_port) B_Req = 1'b0;
            else            A_Req = 1'b0;
         end
         @(negedge Clock);
         check($sformatf("v%0d c%0d oe", idx, c), RAM_Out_Enable, (c >= 1 && c < d));
         check($sformatf("v%0d c%0d rw", idx, c), RAM_Read_H_Write_L, !(wr && c >= 2 && c < d));
         check($sformatf("v%0d c%0d a_done", idx, c), A_Done, (c == d && v.exp_port == PORT_A));
         check($sformatf("v%0d c%0d b_done", idx, c), B_Done, (c == d && v.exp_port == PORT_B));
         check($sformatf("v%0d c%0d a_err", idx, c), A_Err, 1'b0);
         check($sformatf("v%0d c%0d b_err", idx, c), B_Err, 1'b0);
         if (c >= 1) check($sformatf("v%0d c%0d addr", idx, c), RAM_Address, wa);
         if (wr && c >= 2) check($sformatf("v%0d c%0d din", idx, c), RAM_Data_In, wd);
         if (c == d) begin
            if (!wr) exp_rd[v.exp_port] = v.ram_rdata;
            check($sformatf("v%0d a_rdata", idx), A_RData, exp_rd[0]);
            check($sformatf("v%0d b_rdata", idx), B_RData, exp_rd[1]);
         end
         @(posedge Clock); #1;
      end
      if (v.exp_port) B_Req = 1'b0;
      else            A_Req = 1'b0;
      RAM_MFC = 1'b0;
   endtask

   initial begin
      vec_t tail;

      //           a_req a_wr  a_addr  a_wdata          b_req b_wr  b_addr  b_wdata          ram_rdata     wait early drop  port
      vecs[0] = '{1'b1, 1'b1, 6'h01, 32'h0000_0011, 1'b1, 1'b1, 6'h02, 32'h0000_0022, 32'hFFFF_0000, 0, 1'b0, 1'b0, PORT_A};
      vecs[1] = '{1'b0, 1'b0, 6'h00, 32'h0000_0000, 1'b1, 1'b1, 6'h02, 32'h0000_0022, 32'hFFFF_0000, 0, 1'b0, 1'b0, PORT_B};
      vecs[2] = '{1'b1, 1'b0, 6'h05, 32'h0000_0000, 1'b0, 1'b0, 6'h00, 32'h0000_0000, 32'hDEAD_BEEF, 0, 1'b0, 1'b0, PORT_A};
      vecs[3] = '{1'b0, 1'b0, 6'h00, 32'h0000_0000, 1'b1, 1'b0, 6'h02, 32'h0000_0000, 32'h0000_0022, 5, 1'b1, 1'b0, PORT_B};
      vecs[4] = '{1'b1, 1'b0, 6'h3F, 32'h0000_0000, 1'b1, 1'b0, 6'h00, 32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 1'b0, PORT_A};
      vecs[5] = '{1'b0, 1'b0, 6'h00, 32'h0000_0000, 1'b1, 1'b0, 6'h00, 32'h0000_0000, 32'h1234_5678, 2, 1'b0, 1'b0, PORT_B};
      vecs[6] = '{1'b1, 1'b1, 6'h3F, 32'hA5A5_A5A5, 1'b1, 1'b1, 6'h00, 32'h5A5A_5A5A, 32'h0000_0000, 0, 1'b0, 1'b0, PORT_A};
      vecs[7] = '{1'b0, 1'b0, 6'h00, 32'h0000_0000, 1'b1, 1'b1, 6'h00, 32'h5A5A_5A5A, 32'h0000_0000, 1, 1'b0, 1'b0, PORT_B};
      vecs[8] = '{1'b1, 1'b0, 6'h10, 32'h0000_0000, 1'b0, 1'b0, 6'h00, 32'h0000_0000, 32'hCAFE_F00D, 1, 1'b0, 1'b1, PORT_A};
      tail    = '{1'b1, 1'b0, 6'h06, 32'h0000_0000, 1'b0, 1'b0, 6'h00, 32'h0000_0000, 32'h600D_600D, 0, 1'b0, 1'b0, PORT_A};

      Reset_L = 1'b0;
      A_Req = 1'b0; A_Write = 1'b0; A_Addr = '0; A_WData = '0;
      B_Req = 1'b0; B_Write = 1'b0; B_Addr = '0; B_WData = '0;
      RAM_Data_Out = '0; RAM_MFC = 1'b0;
      exp_rd[0] = '0; exp_rd[1] = '0;

      #12;
      check("rst oe",     RAM_Out_Enable, 1'b0);
      check("rst rw",     RAM_Read_H_Write_L, 1'b1);
      check("rst addr",   RAM_Address, 6'h00);
      check("rst din",    RAM_Data_In, 32'h0);
      check("rst a_done", A_Done, 1'b0);
      check("rst b_done", B_Done, 1'b0);
      check("rst a_err",  A_Err, 1'b0);
      check("rst b_err",  B_Err, 1'b0);
      check("rst a_rd",   A_RData, 32'h0);
      check("rst b_rd",   B_RData, 32'h0);
      @(negedge Clock); Reset_L = 1'b1;
      @(posedge Clock); #1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Reset asserted while waiting for MFC drops the access on the spot.
      A_Req = 1'b1; A_Write = 1'b0; A_Addr = 6'h2A; RAM_MFC = 1'b0;
      @(posedge Clock); #1;
      @(posedge Clock); #1;
      @(negedge Clock);
      check("mid wait oe", RAM_Out_Enable, 1'b1);
      check("mid wait addr", RAM_Address, 6'h2A);
      #1 Reset_L = 1'b0; A_Req = 1'b0;
      #1;
      check("mid rst oe", RAM_Out_Enable, 1'b0);
      check("mid rst rw", RAM_Read_H_Write_L, 1'b1);
      check("mid rst addr", RAM_Address, 6'h00);
      check("mid rst a_done", A_Done, 1'b0);
      check("mid rst a_rd", A_RData, 32'h0);
      check("mid rst b_rd", B_RData, 32'h0);
      exp_rd[0] = '0; exp_rd[1] = '0;
      @(posedge Clock);
      @(negedge Clock); Reset_L = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clock);
         check($sformatf("post rst c%0d a_done", c), A_Done, 1'b0);
         check($sformatf("post rst c%0d oe", c), RAM_Out_Enable, 1'b0);
      end
      @(posedge Clock); #1;

      // Both requests held with MFC always high: A, B, A, B, Done every 4 cycles.
      A_Req = 1'b1; A_Write = 1'b0; A_Addr = 6'h07;
      B_Req = 1'b1; B_Write = 1'b0; B_Addr = 6'h08;
      RAM_Data_Out = 32'h0BAD_F00D; RAM_MFC = 1'b1;
      for (int c = 0; c < 16; c++) begin
         @(negedge Clock);
         check($sformatf("rr c%0d a_done", c), A_Done, (c == 3 || c == 11));
         check($sformatf("rr c%0d b_done", c), B_Done, (c == 7 || c == 15));
         if (c % 4 == 1) check($sformatf("rr c%0d addr", c), RAM_Address, (c % 8 == 1) ? 6'h07 : 6'h08);
         @(posedge Clock); #1;
      end
      A_Req = 1'b0; B_Req = 1'b0; RAM_MFC = 1'b0;
      exp_rd[0] = 32'h0BAD_F00D; exp_rd[1] = 32'h0BAD_F00D;
      check("rr a_rd", A_RData, exp_rd[0]);
      check("rr b_rd", B_RData, exp_rd[1]);

      // MFC withheld: abort after the timeout, or wait until MFC finally rises.
      A_Req = 1'b1; A_Write = 1'b0; A_Addr = 6'h05; RAM_Data_Out = 32'h7777_7777;
`ifdef MFC_TIMEOUT_EN
      for (int c = 0; c <= 17; c++) begin
         RAM_MFC = 1'b0;
         @(negedge Clock);
         check($sformatf("to c%0d a_done", c), A_Done, (c == 17));
         check($sformatf("to c%0d a_err", c), A_Err, (c == 17));
         check($sformatf("to c%0d oe", c), RAM_Out_Enable, (c >= 1 && c <= 16));
         if (c == 17) check("to a_rd", A_RData, 32'h0);
         @(posedge Clock); #1;
      end
      exp_rd[0] = 32'h0;
`else
      for (int c = 0; c <= 21; c++) begin
         RAM_MFC = (c == 20);
         @(negedge Clock);
         check($sformatf("wait c%0d a_done", c), A_Done, (c == 21));
         check($sformatf("wait c%0d a_err", c), A_Err, 1'b0);
         check($sformatf("wait c%0d oe", c), RAM_Out_Enable, (c >= 1 && c <= 20));
         if (c == 21) check("wait a_rd", A_RData, 32'h7777_7777);
         @(posedge Clock); #1;
      end
      exp_rd[0] = 32'h7777_7777;
`endif
      A_Req = 1'b0; RAM_MFC = 1'b0;
      run_vec(9, tail);

      // MFC high with no request pending must not start or finish anything.
      RAM_MFC = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge Clock);
         check($sformatf("idle mfc c%0d oe", c), RAM_Out_Enable, 1'b0);
         check($sformatf("idle mfc c%0d a_done", c), A_Done, 1'b0);
         check($sformatf("idle mfc c%0d b_done", c), B_Done, 1'b0);
      end
      RAM_MFC = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
